// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider for unsigned integers.
// It produces one quotient bit per clock and uses valid/ready handshakes on the input and output channels.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;
    logic [WIDTH-1:0] prem_reg, prem_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;
    logic [CW-1:0]    count_reg, count_next;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             qbit;

    // The partial remainder is always below the divisor, so trial < 2*divisor.
    // A borrow out of the top bit is therefore exactly "trial < divisor".
    assign trial = {prem_reg, shift_reg[WIDTH-1]};
    assign diff  = trial - {1'b0, divisor_reg};
    assign qbit  = ~diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            divisor_reg   <= '0;
            prem_reg      <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            shift_reg     <= shift_next;
            divisor_reg   <= divisor_next;
            prem_reg      <= prem_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
            count_reg     <= count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        divisor_next   = divisor_reg;
        prem_next      = prem_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        count_next     = count_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    shift_next   = dividend;
                    divisor_next = divisor;
                    if (divisor == '0) begin
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        state_next     = DONE;
                    end else begin
                        count_next = '0;
                        prem_next  = '0;
                        dbz_next   = 1'b0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                prem_next  = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                shift_next = {shift_reg[WIDTH-2:0], qbit};
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(WIDTH - 1)) begin
                    quotient_next  = {shift_reg[WIDTH-2:0], qbit};
                    remainder_next = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and streaming checks for seq_restoring_divider with WIDTH=8.
// The expected results come from hand-computed tables and from a reference using integer division.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One directed division with out_ready already high; starts and ends at a negedge.
    task automatic run_vec(input vec_t v);
        int   lat;
        logic busy_ok;
        in_valid = 1'b1;
        dividend = v.a;
        divisor  = v.b;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h00;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("quotient", {24'd0, quotient}, {24'd0, v.q});
        chk("remainder", {24'd0, remainder}, {24'd0, v.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, v.z});
        chk("in_ready_busy", {31'd0, busy_ok}, 32'd1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        $display("xact %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", v.a, v.b, quotient, remainder, div_by_zero, lat);
        @(negedge clk);
        chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        chk("hold_in_idle", {24'd0, quotient}, {24'd0, v.q});
    endtask

    initial begin
        logic [7:0]  cur_a, cur_b, ea, eb, eq, er;
        logic [15:0] exp_q[$];
        logic [15:0] item;
        logic        stable, no_stale;
        int          lat, na, nr, cyc;

        vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   z: 1'b0, lat: 8};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0, lat: 8};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0, lat: 8};
        vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0, lat: 8};
        vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   z: 1'b0, lat: 8};
        vecs[5] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, z: 1'b1, lat: 0};
        vecs[6] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   z: 1'b0, lat: 8};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outputs", {15'd0, quotient, remainder, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Backpressure: hold the result for 5 cycles with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd77;
        divisor   = 8'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 8);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (quotient !== 8'd7 || remainder !== 8'd7 || !out_valid || in_ready || div_by_zero)
                stable = 1'b0;
            if (k < 4) @(negedge clk);
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        chk("bp_quotient", {24'd0, quotient}, 32'd7);
        chk("bp_remainder", {24'd0, remainder}, 32'd7);
        $display("xact 77/10 backpressure -> q=%0d r=%0d", quotient, remainder);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a division.
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_outputs", {15'd0, quotient, remainder, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        no_stale = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) no_stale = 1'b0;
        end
        chk("no_stale_result", {31'd0, no_stale}, 32'd1);
        run_vec('{a: 8'd50, b: 8'd6, q: 8'd8, r: 8'd2, z: 1'b0, lat: 8});

        // Back-to-back stream with random consumer backpressure.
        na    = 0;
        nr    = 0;
        cyc   = 0;
        cur_a = 8'($urandom);
        cur_b = 8'($urandom);
        while (nr < 1000 && cyc < 60000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (na < 1000);
            dividend  = cur_a;
            divisor   = cur_b;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream_dup: got extra result q=%0d r=%0d want none", quotient, remainder);
                end else begin
                    item = exp_q.pop_front();
                    ea   = item[15:8];
                    eb   = item[7:0];
                    if (eb == 8'd0) begin
                        eq = 8'hFF;
                        er = ea;
                    end else begin
                        eq = ea / eb;
                        er = ea % eb;
                    end
                    chk($sformatf("stream_%0d_%0d/%0d", nr, ea, eb),
                        {15'd0, quotient, remainder, div_by_zero},
                        {15'd0, eq, er, (eb == 8'd0)});
                    $display("xact stream %0d: %0d/%0d -> q=%0d r=%0d dbz=%0d", nr, ea, eb, quotient, remainder, div_by_zero);
                end
                nr++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({cur_a, cur_b});
                na++;
                cur_a = 8'($urandom);
                cur_b = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", nr, 1000);
        chk("stream_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned integer divider that computes one quotient bit per clock (radix-2 restoring algorithm).
- Serves as the inverse-operation companion to the combinational multi-operand adder/multiplier datapath in the arithmetic library.
- Operands are accepted on a valid/ready input channel.
- Quotient, remainder and a divide-by-zero flag are returned on a valid/ready output channel.
- Exactly one division is in flight at any time.

Parameters:
- WIDTH, 8, bit width of the dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  dividend/divisor are valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  WIDTH  unsigned divisor.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  set with the result when divisor was 0.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n low, any time, including mid-operation):
  - state := IDLE; quotient, remainder, div_by_zero, iteration counter and partial remainder := 0.
  - out_valid = 0 and in_ready = 1 while in reset.
  - An aborted division produces no result.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE), decoded directly from state. out_valid = (state == DONE).
- IDLE:
  - Accept on the edge where in_valid && in_ready.
  - Latch dividend into the shift register and divisor into a holding register.
  - divisor == 0: go directly to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1. out_valid is high in the first cycle after the accepting edge.
  - divisor != 0: go to RUN with counter = 0, partial remainder = 0, div_by_zero = 0.
- RUN, one iteration per edge, WIDTH iterations total:
  - Form trial = {partial remainder, MSB of the dividend shift register}, WIDTH+1 bits.
  - diff = trial - {0, divisor}, WIDTH+1 bits.
  - If trial >= divisor: partial remainder := diff[WIDTH-1:0] and quotient bit = 1.
  - Otherwise: partial remainder := trial[WIDTH-1:0] and quotient bit = 0.
  - Shift the quotient bit into the LSB of the dividend shift register; the register becomes the quotient.
  - On the edge where counter == WIDTH-1: go to DONE and load the quotient/remainder outputs.
  - out_valid rises exactly WIDTH edges after the accepting edge.
- DONE:
  - quotient, remainder and div_by_zero are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: go to IDLE.
  - The outputs keep their last values in IDLE. New operands can be accepted at the earliest one cycle after the handshake (no overlap).
- Inputs are ignored outside IDLE. in_valid asserted during RUN/DONE is not accepted and must be held by the producer.
- Operand changes after acceptance have no effect on the division in progress.
- Invariant for divisor != 0: dividend == quotient*divisor + remainder, and remainder < divisor.
- All arithmetic is unsigned modulo 2^(WIDTH+1) internally. No X outputs after reset.

Test Plan:
- WIDTH=8; reset, then accept 200/7 with out_ready=1 -> out_valid exactly 8 edges after acceptance; quotient=28, remainder=4, div_by_zero=0; in_ready=0 throughout RUN/DONE.
- Boundary operands, in sequence: 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 255/255 -> q=1, r=0; 0/3 -> q=0, r=0.
- 100/0 -> out_valid in the first cycle after acceptance; q=255, r=100, div_by_zero=1. A following 9/3 -> q=3, r=0, div_by_zero=0.
- Backpressure: 77/10 with out_ready low for 5 cycles after out_valid -> q=7, r=7 stable across all 5 cycles; in_ready=0. When out_ready rises, handshake occurs, then in_ready=1 the next cycle.
- Deassert rst_n asynchronously mid-RUN (iteration 4 of 200/7), then release:
  - Immediately: out_valid=0, in_ready=1, outputs 0.
  - No stale result appears.
  - Next accepted 50/6 -> q=8, r=2.
- Randomised back-to-back stream (1000 pairs, in_valid held high, out_ready random) -> every result satisfies the invariant; in order; no lost or duplicated transactions.
